// File: rtl/fifo_pkg.sv
// Shared helpers for the level-reporting FIFO: derived widths, parameter
// legality, and the level-update encoding used by the control logic.
package fifo_pkg;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit cfg_legal(input int data_width, input int depth,
                                     input int af_thresh, input int ae_thresh,
                                     input int fwft);
        return (data_width >= 1) && (depth >= 2) &&
               (af_thresh >= 1) && (af_thresh <= depth) &&
               (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
               ((fwft == 0) || (fwft == 1));
    endfunction

    // How the occupancy counter moves on the coming edge.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2,
        LVL_CLR  = 2'd3
    } lvl_op_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    localparam int PW       = ptr_width(Depth)
) (
    input  logic                 i_clk,
    input  logic                 i_wr_en,
    input  logic [PW-1:0]        i_wr_addr,
    input  logic [DataWidth-1:0] i_wr_data,
    input  logic [PW-1:0]        i_rd_addr,
    output logic [DataWidth-1:0] o_rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    // Store the incoming word at the write pointer.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/fifo_lvl.sv
// Synchronous FIFO with live fill level, threshold flags, sticky error
// flags, synchronous flush and selectable standard / FWFT read mode.
module fifo_lvl
    import fifo_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    parameter int FWFT      = 0,
    parameter int AfThresh  = Depth - 1,
    parameter int AeThresh  = 1,
    localparam int LW       = level_width(Depth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DataWidth-1:0] i_wr_data,
    input  logic                 i_wr_en,
    input  logic                 i_rd_en,
    input  logic                 i_flush,
    input  logic                 i_clr_err,
    output logic [DataWidth-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic [LW-1:0]        o_level,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_almost_full,
    output logic                 o_almost_empty,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    localparam int PW = ptr_width(Depth);
    localparam logic [PW-1:0] PtrLast  = PW'(Depth - 1);
    localparam logic [PW-1:0] PtrOne   = PW'(1);
    localparam logic [LW-1:0] LvlDepth = LW'(Depth);
    localparam logic [LW-1:0] LvlOne   = LW'(1);
    localparam logic [LW-1:0] LvlAf    = LW'(AfThresh);
    localparam logic [LW-1:0] LvlAe    = LW'(AeThresh);

    if (!cfg_legal(DataWidth, Depth, AfThresh, AeThresh, FWFT)) begin : g_cfg_check
        $error("fifo_lvl: illegal DataWidth/Depth/threshold/FWFT combination");
    end

    logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [LW-1:0]        level_reg, level_next;
    logic                 overflow_reg, underflow_reg;
    logic                 full, empty, rd_acc, wr_acc, mem_we;
    logic                 ovf_set, udf_set;
    logic [DataWidth-1:0] mem_rd_data;
    lvl_op_e              lvl_op;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + PtrOne;
    endfunction

    // Status comes only from registered state, never from the strobes.
    assign full   = (level_reg == LvlDepth);
    assign empty  = (level_reg == '0);

    // A read frees a slot this cycle, so a full FIFO may still take a write;
    // an empty FIFO is never read, even alongside a write.
    assign rd_acc  = i_rd_en & ~empty;
    assign wr_acc  = i_wr_en & (~full | rd_acc);
    assign mem_we  = wr_acc & ~i_flush;
    assign ovf_set = i_wr_en & ~wr_acc & ~i_flush;
    assign udf_set = i_rd_en & empty & ~i_flush;

    // Next pointers and level-counter action; flush wins over both strobes.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        lvl_op      = LVL_HOLD;
        if (i_flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            lvl_op      = LVL_CLR;
        end else begin
            if (wr_acc) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (rd_acc) rd_ptr_next = ptr_inc(rd_ptr_reg);
            if (wr_acc && !rd_acc) lvl_op = LVL_INC;
            if (rd_acc && !wr_acc) lvl_op = LVL_DEC;
        end
    end

    // Apply the level-counter action.
    always_comb begin
        level_next = level_reg;
        case (lvl_op)
            LVL_INC: level_next = level_reg + LvlOne;
            LVL_DEC: level_next = level_reg - LvlOne;
            LVL_CLR: level_next = '0;
            default: level_next = level_reg;
        endcase
    end

    // Pointer, level and sticky-error state; a new error beats a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            overflow_reg  <= ovf_set | (overflow_reg & ~i_clr_err);
            underflow_reg <= udf_set | (underflow_reg & ~i_clr_err);
        end
    end

    fifo_mem #(
        .DataWidth(DataWidth),
        .Depth    (Depth)
    ) u_mem (
        .i_clk    (i_clk),
        .i_wr_en  (mem_we),
        .i_wr_addr(wr_ptr_reg),
        .i_wr_data(i_wr_data),
        .i_rd_addr(rd_ptr_reg),
        .o_rd_data(mem_rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero while empty so the
        // uninitialised storage never reaches the output.
        assign o_rd_data  = empty ? '0 : mem_rd_data;
        assign o_rd_valid = ~empty;
    end else begin : g_std
        logic [DataWidth-1:0] rd_data_reg;
        logic                 rd_valid_reg;

        // Capture the head word on an accepted pop; hold it otherwise.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= rd_acc & ~i_flush;
                if (rd_acc && !i_flush) begin
                    rd_data_reg <= mem_rd_data;
                end
            end
        end

        assign o_rd_data  = rd_data_reg;
        assign o_rd_valid = rd_valid_reg;
    end

    assign o_level        = level_reg;
    assign o_full         = full;
    assign o_empty        = empty;
    assign o_almost_full  = (level_reg >= LvlAf);
    assign o_almost_empty = (level_reg <= LvlAe);
    assign o_overflow     = overflow_reg;
    assign o_underflow    = underflow_reg;

endmodule
